// File: rtl/v74x148_pkg.sv
// Shared constants and helpers for the pending-request priority encoder.
// Active-low polarity names keep edge and status logic readable.
package v74x148_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic ASSERTED_L = 1'b0;
  localparam logic IDLE_L     = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational N-to-W highest-index encoder; zero latency, no flow control.
// code is 0 when nothing is requested, so qualify it with any.
module prio_enc
  import v74x148_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         any
);

  always_comb begin
    code = '0;
    any  = |req;
    for (int i = 0; i < N; i++) begin
      if (req[i]) code = W'(i);
    end
  end

endmodule

// File: rtl/v74x148_pend_enc.sv
// Latches falling request edges as pending and streams the highest pending index out;
// 2-cycle edge-to-VALID latency, Y/VALID held under backpressure, repeat edges on a pending line pulse DROP.
module v74x148_pend_enc
  import v74x148_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EI_L,
  input  logic [N-1:0] I_L,
  output logic [W-1:0] Y,
  output logic         VALID,
  input  logic         READY,
  output logic         GS_L,
  output logic         EO_L,
  output logic         DROP
);

  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;

  logic [N-1:0] fall;
  logic [N-1:0] load_mask;
  logic [W-1:0] enc_code;
  logic         enc_any;
  logic         slot_free;
  logic         load;

  prio_enc #(.N(N)) u_prio_enc (
    .req  (pending_q),
    .code (enc_code),
    .any  (enc_any)
  );

  always_comb begin
    fall = '0;
    if (EI_L == ASSERTED_L) fall = prev_q & ~I_L;
  end

  // Output register is free when empty or being drained this cycle.
  assign slot_free = !valid_q || READY;
  assign load      = slot_free && enc_any;

  always_comb begin
    load_mask = '0;
    if (load) load_mask[enc_code] = 1'b1;
  end

  always_comb begin
    prev_d    = I_L;
    pending_d = (pending_q & ~load_mask) | fall;
    drop_d    = |(fall & pending_q & ~load_mask);
    y_d       = y_q;
    valid_d   = valid_q;
    if (load) begin
      y_d     = enc_code;
      valid_d = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // prev_q resets low so a line already held low at release never looks like an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q    <= '0;
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign DROP  = drop_q;
  assign GS_L  = (valid_q || (|pending_q)) ? ASSERTED_L : IDLE_L;
  assign EO_L  = ((EI_L == ASSERTED_L) && !valid_q && !(|pending_q)) ? ASSERTED_L : IDLE_L;

endmodule

// File: tb/tb_v74x148_pend_enc.sv
// Directed bench for v74x148_pend_enc: expected codes are queued at stimulus time
// and popped by a monitor whenever a VALID&READY transfer is about to occur.
module tb_v74x148_pend_enc;

  localparam int N = 4;
  localparam int W = 2;

  logic         CLK;
  logic         RST;
  logic         EI_L;
  logic [N-1:0] I_L;
  logic [W-1:0] Y;
  logic         VALID;
  logic         READY;
  logic         GS_L;
  logic         EO_L;
  logic         DROP;

  int vectors     = 0;
  int miscompares = 0;
  int xfer_cnt    = 0;
  int xfer_base;
  int sb[$];

  v74x148_pend_enc #(.N(N)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EI_L  (EI_L),
    .I_L   (I_L),
    .Y     (Y),
    .VALID (VALID),
    .READY (READY),
    .GS_L  (GS_L),
    .EO_L  (EO_L),
    .DROP  (DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so at the falling edge
  // VALID&READY reliably predicts a transfer at the next rising edge.
  always @(negedge CLK) begin
    if (!RST && VALID && READY) begin
      if (sb.size() > 0) begin
        chk("xfer_y", 32'(Y), 32'(sb.pop_front()));
        xfer_cnt++;
      end else begin
        chk("xfer_spurious_sb_depth", 32'(sb.size()), 32'd1);
      end
    end
  end

  initial begin
    RST   = 1'b1;
    EI_L  = 1'b0;
    I_L   = 4'b1111;
    READY = 1'b0;

    // Reset values, then a line held low across release is never captured.
    tick(2);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_y",     32'(Y),     32'd0);
    chk("rst_gs_l",  32'(GS_L),  32'd1);
    chk("rst_eo_l",  32'(EO_L),  32'd0);
    chk("rst_drop",  32'(DROP),  32'd0);
    I_L = 4'b1110;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_release_valid", 32'(VALID), 32'd0);
    end
    chk("rst_release_gs_l", 32'(GS_L), 32'd1);
    I_L = 4'b1111;
    tick();

    // Single request on line 2.
    READY = 1'b1;
    I_L   = 4'b1011;
    sb.push_back(2);
    tick();
    chk("single_gs_l_pending", 32'(GS_L),  32'd0);
    chk("single_valid_early",  32'(VALID), 32'd0);
    tick();
    chk("single_valid", 32'(VALID), 32'd1);
    chk("single_y",     32'(Y),     32'd2);
    tick();
    chk("single_valid_after", 32'(VALID), 32'd0);
    chk("single_gs_l_after",  32'(GS_L),  32'd1);
    chk("single_eo_l_after",  32'(EO_L),  32'd0);
    I_L = 4'b1111;
    tick();

    // Simultaneous edges on lines 3 and 0, delivered highest first.
    READY = 1'b0;
    I_L   = 4'b0110;
    sb.push_back(3);
    sb.push_back(0);
    tick(2);
    chk("simul_valid", 32'(VALID), 32'd1);
    chk("simul_y",     32'(Y),     32'd3);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("simul_hold_valid", 32'(VALID), 32'd1);
      chk("simul_hold_y",     32'(Y),     32'd3);
    end
    READY = 1'b1;
    tick();
    chk("simul_second_valid", 32'(VALID), 32'd1);
    chk("simul_second_y",     32'(Y),     32'd0);
    tick();
    chk("simul_drained_valid", 32'(VALID), 32'd0);
    I_L = 4'b1111;
    tick();

    // Backpressure: repeat pulses on line 1; third edge is dropped.
    READY     = 1'b0;
    xfer_base = xfer_cnt;
    I_L = 4'b1101;
    sb.push_back(1);
    tick();
    I_L = 4'b1111;
    chk("bp_drop_first", 32'(DROP), 32'd0);
    tick();
    chk("bp_valid", 32'(VALID), 32'd1);
    chk("bp_y",     32'(Y),     32'd1);
    I_L = 4'b1101;
    sb.push_back(1);
    tick();
    chk("bp_drop_second", 32'(DROP), 32'd0);
    I_L = 4'b1111;
    tick();
    I_L = 4'b1101;
    tick();
    chk("bp_drop_pulse", 32'(DROP), 32'd1);
    I_L = 4'b1111;
    tick();
    chk("bp_drop_clear", 32'(DROP), 32'd0);
    chk("bp_y_stable",   32'(Y),    32'd1);
    READY = 1'b1;
    tick(3);
    chk("bp_drained_valid", 32'(VALID), 32'd0);
    chk("bp_xfer_count",    32'(xfer_cnt - xfer_base), 32'd2);

    // Enable off: line 2 drains, line 3 edge is ignored.
    READY = 1'b0;
    I_L   = 4'b1011;
    sb.push_back(2);
    tick();
    EI_L = 1'b1;
    #1;
    chk("en_off_eo_l_pending", 32'(EO_L), 32'd1);
    tick();
    chk("en_off_valid", 32'(VALID), 32'd1);
    chk("en_off_y",     32'(Y),     32'd2);
    I_L = 4'b0011;
    tick();
    chk("en_off_eo_l_busy", 32'(EO_L), 32'd1);
    chk("en_off_gs_l_busy", 32'(GS_L), 32'd0);
    READY = 1'b1;
    tick(3);
    chk("en_off_valid_drained", 32'(VALID), 32'd0);
    chk("en_off_gs_l_drained",  32'(GS_L),  32'd1);
    chk("en_off_eo_l_drained",  32'(EO_L),  32'd1);
    I_L = 4'b1111;
    tick();
    EI_L = 1'b0;
    #1;
    chk("en_on_eo_l", 32'(EO_L), 32'd0);
    tick();

    // Reset mid-transaction: held code and pending line 0 are discarded.
    READY = 1'b0;
    I_L   = 4'b0110;
    tick(2);
    chk("midrst_valid_before", 32'(VALID), 32'd1);
    chk("midrst_y_before",     32'(Y),     32'd3);
    RST = 1'b1;
    #1;
    chk("midrst_valid", 32'(VALID), 32'd0);
    chk("midrst_y",     32'(Y),     32'd0);
    chk("midrst_gs_l",  32'(GS_L),  32'd1);
    chk("midrst_eo_l",  32'(EO_L),  32'd0);
    chk("midrst_drop",  32'(DROP),  32'd0);
    tick();
    RST   = 1'b0;
    READY = 1'b1;
    xfer_base = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_valid", 32'(VALID), 32'd0);
      chk("midrst_no_drop",  32'(DROP),  32'd0);
    end
    chk("midrst_xfer_count", 32'(xfer_cnt - xfer_base), 32'd0);
    I_L = 4'b1111;
    tick(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/v74x148_pend_enc.md
# v74x148_pend_enc

Sequential priority encoder with pending-request latching, the encode-side counterpart of the 2-to-4 active-low decoder. Captures falling edges on active-low request lines, holds them as pending, and presents the highest-index pending line as a binary code over a valid/ready handshake. The binary code drives the decoder's select inputs (A = code bit 0, B = code bit 1) directly. Status pins mirror 74x148 group-select and enable-out semantics.

## Interface
- N, 4, number of request lines; power of 2, 2..8
- W, clog2(N), derived localparam, code width (2 for N=4)

- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- EI_L  input  1  capture enable, active-low
- I_L  input  N  request lines, active-low, synchronous to CLK
- Y  output  W  encoded line index, active-high binary, registered
- VALID  output  1  Y holds an undelivered request, registered
- READY  input  1  consumer accepts Y when VALID & READY at a rising edge
- GS_L  output  1  low when VALID=1 or any bit pending
- EO_L  output  1  low when EI_L=0, VALID=0 and nothing pending
- DROP  output  1  one-cycle pulse: request lost, registered

## Operation
- prev_l[N]: registered copy of I_L.
- Edge on line k in a cycle: prev_l[k]=1 & I_L[k]=0 & EI_L=0.
- With EI_L=1, edges are ignored. Existing pending bits and the output stage continue to drain.
- pending[N] update, applied in this order:
  - A bit loaded into the output stage this cycle is cleared.
  - A same-cycle edge on that same line re-sets the bit. This does not count as a drop.
- Load condition: load = (VALID=0 | READY=1) & |pending.
- On load:
  - Y <= highest set index of pending (fixed priority; N-1 highest).
  - VALID <= 1.
  - That bit leaves pending.
- If VALID=0 or READY=1, and pending is empty: VALID <= 0. Y holds its last value.
- While VALID=1 & READY=0: Y and VALID are stable.
- DROP <= 1 in the cycle after an edge on line k when both hold:
  - pending[k]=1 already.
  - k is not being loaded that cycle.
- The request that caused the DROP is discarded. Pending remains 1.
- GS_L and EO_L are combinational from the registers and EI_L.

## Timing
- Reset values, async on RST=1:
  - pending=0
  - prev_l=0: a line held low across reset release is never captured.
  - Y=0, VALID=0, DROP=0, GS_L=1, EO_L=EI_L
- Latency: edge sampled at rising edge t, so pending is set after edge t, and VALID=1 with Y valid after edge t+1 (2 cycles).
- Throughput: one code per cycle while READY=1 and pending is non-empty.
- Handshake: VALID is never retracted without VALID & READY. Y does not change while VALID=1 & READY=0.
- Simultaneous edges are all captured in the same cycle and delivered highest index first.
- Reset mid-transaction discards the held code and all pending bits. No DROP is generated.

## Structure
- Shared package/include `v74x148_pkg`:
  - N default
  - clog2 function
  - active-low polarity constants: ASSERTED_L=0, IDLE_L=1
- One sub-module, `prio_enc`:
  - Combinational N-to-W highest-index encoder.
  - Outputs: code and any.
  - Instantiated once on pending.
- Top level contains:
  - edge detect
  - pending register
  - output stage
  - DROP register

## Test plan
- Reset:
  - Stimulus: RST=1 with EI_L=0, I_L=1111.
  - Response: VALID=0, Y=0, GS_L=1, EO_L=0, DROP=0. Hold I_L=1110 through RST release; VALID stays 0 for 10 cycles.
- Single request:
  - Stimulus: EI_L=0, READY=1; I_L 1111→1011 sampled at edge 10.
  - Response: GS_L=0 after edge 10; VALID=1, Y=2 after edge 11; VALID=0, GS_L=1, EO_L=0 after edge 12.
- Simultaneous edges:
  - Stimulus: I_L 1111→0110 at edge 5, READY=0.
  - Response: VALID=1, Y=3 after edge 6, held stable. Raise READY before edge 9: Y=0 after edge 9, VALID=0 after edge 10.
- Backpressure and drop:
  - Stimulus: READY=0; line 1 pulses low at edges 2, 5, 8.
  - Response: Y=1 VALID=1 after edge 3. Edge 5 sets pending[1] with DROP=0. Edge 8 gives DROP=1 for exactly one cycle after edge 8. With READY=1, exactly two Y=1 transfers occur.
- Enable off:
  - Stimulus: line 2 pending, then EI_L=1; line 3 falls.
  - Response: Y=2 is delivered, line 3 is never reported; EO_L=1 throughout; GS_L=1 after drain.
- Reset mid-operation:
  - Stimulus: VALID=1 Y=3, pending={0}, RST pulse.
  - Response: all outputs at reset values immediately (asynchronous); no delivery afterwards.
